// File: rtl/myproject_mul_arb_pkg.sv
// Shared widths, pipeline stage payload and round-robin search helper
// for the shared multiplier arbiter.
package myproject_mul_arb_pkg;

    localparam int unsigned A_W      = 16;
    localparam int unsigned B_W      = 14;
    localparam int unsigned P_W      = 29;
    localparam int unsigned MAX_REQ  = 8;
    localparam int unsigned MAX_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
        logic [A_W-1:0]      a;
        logic [B_W-1:0]      b;
    } stage_t;

    // Returns {found, index} of the first valid lane at or after ptr, modulo n.
    function automatic logic [MAX_ID_W:0] rr_pick(
        input logic [MAX_REQ-1:0]  valid,
        input logic [MAX_ID_W-1:0] ptr,
        input int unsigned         n
    );
        logic [MAX_ID_W:0] pick;
        int unsigned       idx;
        pick = '0;
        idx  = 0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = (32'(ptr) + k) % n;
            if (k < n && !pick[MAX_ID_W] && valid[idx[MAX_ID_W-1:0]]) begin
                pick = {1'b1, idx[MAX_ID_W-1:0]};
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/myproject_mul_share_arb_if.sv
// Request/result bus between the PE lanes, the shared multiplier and the
// downstream result consumer.
interface myproject_mul_share_arb_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
);
    import myproject_mul_arb_pkg::*;

    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [A_W*N_REQ-1:0] req_a;
    logic [B_W*N_REQ-1:0] req_b;
    logic                 res_valid;
    logic                 res_ready;
    logic [ID_W-1:0]      res_id;
    logic [P_W-1:0]       res_data;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_id, res_data
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_id, res_data
    );

endinterface

// File: rtl/myproject_mul_arb_rr.sv
// Round-robin picker: one-hot grant from the pointer position, pointer moves
// past the granted lane on every fired handshake.
module myproject_mul_arb_rr
    import myproject_mul_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic [N_REQ-1:0] req_valid,
    input  logic             advance,
    output logic [N_REQ-1:0] grant_c,
    output logic [ID_W-1:0]  gidx_c,
    output logic             fire_c
);

    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   ptr_d;
    logic [MAX_ID_W:0] pick_c;

    assign pick_c = rr_pick(MAX_REQ'(req_valid), MAX_ID_W'(ptr_q), N_REQ);

    // Grant is suppressed under reset and while the pipeline is stalled.
    always_comb begin
        grant_c = '0;
        gidx_c  = ID_W'(pick_c[MAX_ID_W-1:0]);
        fire_c  = pick_c[MAX_ID_W] && advance && ap_rst_n;
        ptr_d   = ptr_q;
        if (fire_c) begin
            grant_c[gidx_c] = 1'b1;
            ptr_d           = ID_W'((32'(gidx_c) + 32'd1) % N_REQ);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/myproject_mul_share_arb.sv
// One 16x14 multiplier time-shared among N_REQ lanes, with a globally stalled
// operand pipeline and a tagged, backpressured result register.
module myproject_mul_share_arb
    import myproject_mul_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    myproject_mul_share_arb_if.slave bus,
    output logic busy
);

    localparam int unsigned PROD_W = A_W + B_W;

    logic                     advance_c;
    logic                     fire_c;
    logic [N_REQ-1:0]         grant_c;
    logic [ID_W-1:0]          gidx_c;
    logic signed [PROD_W-1:0] prod_c;

    stage_t [MUL_LAT-1:0] stg_q, stg_d;
    logic                 res_valid_q, res_valid_d;
    logic [ID_W-1:0]      res_id_q, res_id_d;
    logic [P_W-1:0]       res_data_q, res_data_d;
    logic                 busy_q, busy_d;

    assign advance_c = !res_valid_q || bus.res_ready;

    myproject_mul_arb_rr #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (bus.req_valid),
        .advance   (advance_c),
        .grant_c   (grant_c),
        .gidx_c    (gidx_c),
        .fire_c    (fire_c)
    );

    // b is unsigned, so it is zero-extended before the signed multiply.
    assign prod_c = PROD_W'($signed(stg_q[MUL_LAT-1].a))
                  * PROD_W'($signed({1'b0, stg_q[MUL_LAT-1].b}));

    always_comb begin
        stg_d       = stg_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_data_d  = res_data_q;
        if (advance_c) begin
            stg_d[0].valid = fire_c;
            stg_d[0].id    = MAX_ID_W'(gidx_c);
            stg_d[0].a     = bus.req_a[A_W*gidx_c +: A_W];
            stg_d[0].b     = bus.req_b[B_W*gidx_c +: B_W];
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                stg_d[i] = stg_q[i-1];
            end
            res_valid_d = stg_q[MUL_LAT-1].valid;
            res_id_d    = ID_W'(stg_q[MUL_LAT-1].id);
            res_data_d  = prod_c[P_W-1:0];
        end
        busy_d = res_valid_d;
        for (int unsigned i = 0; i < MUL_LAT; i++) begin
            busy_d = busy_d | stg_d[i].valid;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stg_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            stg_q       <= stg_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready = grant_c;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_data  = res_data_q;
    assign busy          = busy_q;

endmodule
